// File: rtl/feature_spi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : feature_spi_tx_pkg
//  Description : Shared constants and types for the feature SPI transmitter:
//                feature/frame widths, frame type and the transmit FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package feature_spi_tx_pkg;

    localparam int c_FEATURE_W        = 8;
    localparam int c_NUM_CONV_FILTERS = 6;
    localparam int c_FRAME_W          = c_FEATURE_W * c_NUM_CONV_FILTERS;

    typedef logic signed [c_FEATURE_W-1:0] feature_t;
    typedef logic        [c_FRAME_W-1:0]   frame_t;

    // Transmit FSM state encoding
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t c_ST_IDLE  = 2'd0;
    localparam tx_state_t c_ST_SETUP = 2'd1;
    localparam tx_state_t c_ST_SHIFT = 2'd2;
    localparam tx_state_t c_ST_HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/feature_spi_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : feature_spi_tx_fifo
//  Description : Synchronous frame FIFO (distributed RAM, registered read).
//                A push on a full FIFO and a pop on an empty FIFO are
//                ignored; full/empty derive from the registered count.
//  Ports       : i_clk, i_rst_n          clock, async active-low reset
//                i_push, i_push_data     write strobe and frame
//                i_pop, o_pop_data       read strobe; data valid next cycle
//                o_full, o_empty, o_count occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module feature_spi_tx_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_pop_data;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_count == c_DEPTH_CNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_pop_data;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Storage carries no reset so it maps onto distributed RAM
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_pop_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/feature_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : feature_spi_tx
//  Description : Buffers frames of pooled features and transmits each one as
//                an SPI mode-0 master: MSB first, feature 0 first, one chip
//                select window per frame.
//  Ports       : i_clk, i_rst_n               clock, async active-low reset
//                i_features_valid, i_features frame strobe and features
//                o_ready                      frame FIFO not full
//                o_sclk, o_mosi, o_cs_n       SPI bus (registered)
//                o_busy                       transmit activity pending
//                o_overflow                   sticky frame-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module feature_spi_tx
    import feature_spi_tx_pkg::*;
#(
    parameter int NUM_FEATURES = c_NUM_CONV_FILTERS,
    parameter int FEATURE_W    = c_FEATURE_W,
    parameter int SCLK_DIV     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_features_valid,
    input  logic [0:NUM_FEATURES-1][FEATURE_W-1:0] i_features,
    output logic                                   o_ready,
    output logic                                   o_sclk,
    output logic                                   o_mosi,
    output logic                                   o_cs_n,
    output logic                                   o_busy,
    output logic                                   o_overflow
);

    localparam int c_FRAME_BITS = NUM_FEATURES * FEATURE_W;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS);
    localparam int c_DIV_W      = $clog2(SCLK_DIV);
    localparam int c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_BITS - 1);

    // Registered state
    tx_state_t               r_state;
    logic [c_DIV_W-1:0]      r_div_cnt;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_cs_n;
    logic                    r_overflow;

    // Next-state values
    tx_state_t               w_state_nxt;
    logic [c_DIV_W-1:0]      w_div_nxt;
    logic [c_BIT_W-1:0]      w_bit_nxt;
    logic [c_FRAME_BITS-1:0] w_shift_nxt;
    logic                    w_sclk_nxt;
    logic                    w_mosi_nxt;
    logic                    w_cs_n_nxt;
    logic                    w_pop;
    logic                    w_div_done;

    // FIFO interface
    logic [c_FRAME_BITS-1:0] w_push_frame;
    logic [c_FRAME_BITS-1:0] w_fifo_rd_data;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [c_CNT_W-1:0]      w_fifo_count;

    // Feature 0 sits in the most significant byte, so it leaves first
    assign w_push_frame = i_features;

    feature_spi_tx_fifo #(
        .DATA_W (c_FRAME_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_features_valid),
        .i_push_data (w_push_frame),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_div_done = (r_div_cnt == c_DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_SETUP;
                    w_div_nxt   = '0;
                    w_bit_nxt   = c_BIT_LAST;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            c_ST_SETUP: begin
                w_div_nxt = r_div_cnt + 1'b1;
                // FIFO read is registered: the popped frame is visible one
                // cycle after the pop, well before the first rising edge.
                if (r_div_cnt == '0) begin
                    w_shift_nxt = w_fifo_rd_data;
                    w_mosi_nxt  = w_fifo_rd_data[c_FRAME_BITS-1];
                end
                if (w_div_done) begin
                    w_state_nxt = c_ST_SHIFT;
                    w_div_nxt   = '0;
                end
            end
            c_ST_SHIFT: begin
                w_div_nxt = r_div_cnt + 1'b1;
                if (w_div_done) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == '0) begin
                            w_state_nxt = c_ST_HOLD;
                            w_cs_n_nxt  = 1'b1;
                            w_mosi_nxt  = 1'b0;
                        end else begin
                            // Rotate rather than shift so the register is
                            // fully consumed; the wrapped bits never reach mosi.
                            w_shift_nxt = {r_shift[c_FRAME_BITS-2:0], r_shift[c_FRAME_BITS-1]};
                            w_mosi_nxt  = r_shift[c_FRAME_BITS-2];
                            w_bit_nxt   = r_bit_cnt - 1'b1;
                        end
                    end
                end
            end
            c_ST_HOLD: begin
                w_div_nxt = r_div_cnt + 1'b1;
                if (w_div_done) begin
                    w_state_nxt = c_ST_IDLE;
                    w_div_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
        end
    end

    // Upstream cannot stall, so a push into a full FIFO is lost and flagged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_features_valid && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_ready    = !w_fifo_full;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_cs_n     = r_cs_n;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state != c_ST_IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_feature_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feature_spi_tx
//  Description : Self-checking bench for feature_spi_tx. Two instances: the
//                default divider and a divide-by-2 build. SPI monitors
//                reassemble frames from sclk rising edges and compare them
//                with the frames the bench pushed and expects to be accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_spi_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic            v0 = 1'b0;
    logic [0:5][7:0] feat0 = '0;
    logic ready0, sclk0, mosi0, cs_n0, busy0, ovf0;

    logic            v1 = 1'b0;
    logic [0:5][7:0] feat1 = '0;
    logic ready1, sclk1, mosi1, cs_n1, busy1, ovf1;

    logic [47:0] exp0 [$];
    logic [47:0] rx0  [$];
    logic [47:0] exp1 [$];
    logic [47:0] rx1  [$];

    logic [47:0] sh0 = '0, sh1 = '0;
    int nb0 = 0, nb1 = 0;
    int edges0 = 0, edges1 = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    feature_spi_tx #(.SCLK_DIV(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_features_valid(v0), .i_features(feat0),
        .o_ready(ready0), .o_sclk(sclk0), .o_mosi(mosi0), .o_cs_n(cs_n0),
        .o_busy(busy0), .o_overflow(ovf0)
    );

    feature_spi_tx #(.SCLK_DIV(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_features_valid(v1), .i_features(feat1),
        .o_ready(ready1), .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs_n1),
        .o_busy(busy1), .o_overflow(ovf1)
    );

    // SPI receivers: sample mosi on sclk rise inside a cs_n window; a window
    // that closes with a full 48 bits is a received frame.
    always @(posedge sclk0 or negedge cs_n0 or posedge cs_n0) begin
        if (cs_n0) begin
            if (nb0 == 48) rx0.push_back(sh0);
            nb0 <= 0;
        end else if (sclk0) begin
            sh0 <= {sh0[46:0], mosi0};
            nb0 <= nb0 + 1;
        end else begin
            nb0 <= 0;
        end
    end

    always @(posedge sclk1 or negedge cs_n1 or posedge cs_n1) begin
        if (cs_n1) begin
            if (nb1 == 48) rx1.push_back(sh1);
            nb1 <= 0;
        end else if (sclk1) begin
            sh1 <= {sh1[46:0], mosi1};
            nb1 <= nb1 + 1;
        end else begin
            nb1 <= 0;
        end
    end

    always @(posedge sclk0) edges0 <= edges0 + 1;
    always @(posedge sclk1) edges1 <= edges1 + 1;

    function automatic logic [47:0] rand_frame();
        logic [47:0] f;
        f[31:0]  = $urandom();
        f[47:32] = 16'($urandom());
        return f;
    endfunction

    task automatic push0(input logic [47:0] f);
        feat0 = f;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic push1(input logic [47:0] f);
        feat1 = f;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b expected 0", sclk0); end
        n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b expected 0", mosi0); end
        n_cmp++; if (cs_n0 !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b expected 1", cs_n0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", ovf0); end
        n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready0); end
    endtask

    task automatic test_single_frame();
        logic [47:0] f, got;
        int busy_cyc, cs_cyc, guard, e;
        f = 48'h7F80_01FF_005A;
        e = edges0;
        push0(f);
        busy_cyc = 0; cs_cyc = 0; guard = 0;
        while (busy0 === 1'b1 && guard < 2000) begin
            busy_cyc++;
            if (cs_n0 === 1'b0) cs_cyc++;
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (busy_cyc !== 393) begin n_err++; $display("FAIL single_busy_cycles: got %0d expected 393", busy_cyc); end
        n_cmp++; if (cs_cyc !== 388) begin n_err++; $display("FAIL single_cs_low_cycles: got %0d expected 388", cs_cyc); end
        n_cmp++; if (edges0 - e !== 48) begin n_err++; $display("FAIL single_sclk_edges: got %0d expected 48", edges0 - e); end
        n_cmp++;
        if (rx0.size() == 0) begin
            n_err++; $display("FAIL single_frame: got none expected %h", f);
        end else begin
            got = rx0.pop_front();
            if (got !== f) begin n_err++; $display("FAIL single_frame: got %h expected %h", got, f); end
        end
    endtask

    task automatic test_overflow();
        logic [47:0] f, e, got;
        int guard;
        f = rand_frame(); push0(f); exp0.push_back(f);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            f = rand_frame(); push0(f); exp0.push_back(f);
            n_cmp++;
            if (ready0 !== (i < 3)) begin n_err++; $display("FAIL ovf_ready_after_push%0d: got %b expected %b", i, ready0, (i < 3)); end
        end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_flag_before_drop: got %b expected 0", ovf0); end
        push0(rand_frame());
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_flag_after_drop: got %b expected 1", ovf0); end
        n_cmp++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL ovf_ready_full: got %b expected 0", ready0); end
        guard = 0;
        while (busy0 === 1'b1 && guard < 2100) begin @(negedge clk); guard++; end
        n_cmp++; if (guard >= 2100) begin n_err++; $display("FAIL ovf_drain_timeout: got busy %b expected 0", busy0); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            n_cmp++;
            if (rx0.size() == 0) begin
                n_err++; $display("FAIL ovf_frame: got none expected %h", e);
            end else begin
                got = rx0.pop_front();
                if (got !== e) begin n_err++; $display("FAIL ovf_frame: got %h expected %h", got, e); end
            end
        end
        n_cmp++; if (rx0.size() != 0) begin n_err++; $display("FAIL ovf_extra_frames: got %0d expected 0", rx0.size()); end
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf0); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] f, e, got;
        int guard, gap;
        f = rand_frame(); push0(f); exp0.push_back(f);
        repeat (100) @(negedge clk);
        f = rand_frame(); push0(f); exp0.push_back(f);
        guard = 0;
        while (cs_n0 === 1'b0 && guard < 1000) begin @(negedge clk); guard++; end
        gap = 0;
        while (cs_n0 === 1'b1 && gap < 100) begin @(negedge clk); gap++; end
        n_cmp++; if (gap !== 5) begin n_err++; $display("FAIL b2b_cs_gap: got %0d expected 5", gap); end
        guard = 0;
        while (busy0 === 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        n_cmp++; if (guard >= 1000) begin n_err++; $display("FAIL b2b_drain_timeout: got busy %b expected 0", busy0); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            n_cmp++;
            if (rx0.size() == 0) begin
                n_err++; $display("FAIL b2b_frame: got none expected %h", e);
            end else begin
                got = rx0.pop_front();
                if (got !== e) begin n_err++; $display("FAIL b2b_frame: got %h expected %h", got, e); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard, e;
        push0(rand_frame());
        guard = 0;
        while (nb0 != 20 && guard < 1000) begin @(negedge clk); guard++; end
        n_cmp++; if (guard >= 1000) begin n_err++; $display("FAIL midrst_reach_bit20: got %0d bits expected 20", nb0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cs_n0 !== 1'b1) begin n_err++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n0); end
        n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL midrst_sclk: got %b expected 0", sclk0); end
        n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL midrst_mosi: got %b expected 0", mosi0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
        n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b expected 0", ovf0); end
        e = edges0;
        repeat (50) @(negedge clk);
        n_cmp++; if (edges0 !== e) begin n_err++; $display("FAIL midrst_sclk_edges: got %0d expected %0d", edges0, e); end
        n_cmp++; if (rx0.size() != 0) begin n_err++; $display("FAIL midrst_partial_frame: got %0d frames expected 0", rx0.size()); end
    endtask

    task automatic test_idle();
        int e, bad;
        e = edges0; bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cs_n0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        n_cmp++; if (edges0 !== e) begin n_err++; $display("FAIL idle_sclk_edges: got %0d expected %0d", edges0, e); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_cs_n_busy: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [47:0] f, e, got;
        int guard;
        f = rand_frame(); push1(f); exp1.push_back(f);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            f = rand_frame(); push1(f); exp1.push_back(f);
        end
        guard = 0;
        while (cs_n1 !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        n_cmp++; if (guard >= 1000) begin n_err++; $display("FAIL pp_hold_timeout: got cs_n %b expected 1", cs_n1); end
        // Two HOLD cycles then one IDLE cycle: the next push lands on the pop edge
        repeat (2) @(negedge clk);
        f = rand_frame(); push1(f); exp1.push_back(f);
        n_cmp++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL pp_ready_at3: got %b expected 1", ready1); end
        f = rand_frame(); push1(f); exp1.push_back(f);
        n_cmp++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL pp_ready_full: got %b expected 0", ready1); end
        n_cmp++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL pp_overflow_early: got %b expected 0", ovf1); end
        push1(rand_frame());
        n_cmp++; if (ovf1 !== 1'b1) begin n_err++; $display("FAIL pp_overflow: got %b expected 1", ovf1); end
        guard = 0;
        while (busy1 === 1'b1 && guard < 1500) begin @(negedge clk); guard++; end
        n_cmp++; if (guard >= 1500) begin n_err++; $display("FAIL pp_drain_timeout: got busy %b expected 0", busy1); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_cmp++;
            if (rx1.size() == 0) begin
                n_err++; $display("FAIL pp_frame: got none expected %h", e);
            end else begin
                got = rx1.pop_front();
                if (got !== e) begin n_err++; $display("FAIL pp_frame: got %h expected %h", got, e); end
            end
        end
        n_cmp++; if (rx1.size() != 0) begin n_err++; $display("FAIL pp_extra_frames: got %0d expected 0", rx1.size()); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle();
        test_push_pop_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
